hms_seg7_scan: RTL and testbench
================================

Name: hms_seg7_scan

Overview:
Downstream consumer of the hours/min/sec time-of-day counter. Takes the three 6-bit binary fields and drives a 6-digit multiplexed common-anode seven-segment display (HH.MM.SS). Internally it:
- snapshots the time once per scan frame, so the display never tears;
- converts each field to two BCD digits;
- time-multiplexes the digit anodes at a programmable refresh rate.

Parameters:
REFRESH_DIV, 50000, clk cycles each digit stays lit; legal range is 2 or more.
BLANK_HTENS, 0, when 1 the hours-tens digit is blanked if it is zero.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
en  in  1  display enable; 0 turns all anodes off and freezes the scan.
hours  in  6  binary hours; valid range 0..23.
min  in  6  binary minutes; valid range 0..59.
sec  in  6  binary seconds; valid range 0..59.
an  out  6  digit anodes, active-low, one-hot; bit0 is the rightmost digit (seconds ones).
seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
dp  out  1  decimal point (separator), active-low.

Behaviour:
- Reset (reset_n=0, asynchronous): an=6'b111111, seg=7'b1111111, dp=1. Refresh counter=0, digit index=0, snapshot registers=0.
- Refresh counter:
  - counts 0..REFRESH_DIV-1 while en=1;
  - at terminal count it returns to 0 and the digit index advances 0→1→…→5→0.
- Frame snapshot:
  - hours/min/sec are captured only in the cycle where the counter is at terminal count and index=5, i.e. simultaneously with the 5→0 wrap;
  - input changes at any other time have no effect until the next wrap;
  - the first frame after reset shows 00.00.00.
- Digit map:
  - idx0 = sec ones, idx1 = sec tens;
  - idx2 = min ones, idx3 = min tens;
  - idx4 = hours ones, idx5 = hours tens.
- Output timing: an/seg/dp are registered and reflect the new index one cycle after the index register changes.
  - an = ~(1<<idx).
  - Exactly one anode is low when en=1. No cycle may have two anodes low.
- BCD conversion: tens = value/10, ones = value%10, computed on snapshot values. The divide is fixed-range (0..63), so no general divider is used.
- Range check, applied per field:
  - hours>23, or min>59, or sec>59, makes both digits of that field display a dash (seg=7'b0111111);
  - other fields are unaffected.
- BLANK_HTENS=1 with hours tens = 0 and hours valid: idx5 shows seg=7'b1111111. Its anode is still driven, so the scan timing is unchanged.
- dp:
  - low on idx2 and idx4 when snapshot sec is even, giving a 1 Hz blink;
  - high on all other digits and whenever sec is odd or invalid.
- en=0:
  - the next cycle gives an=6'b111111, seg=7'b1111111, dp=1;
  - counter, index and snapshot hold their values;
  - when en returns to 1, scanning resumes from the held index and count.
- Reset mid-frame: immediate return to the reset values listed above, with no glitch pulse on any anode.

Decomposition:
- Shared package (seg7_pkg) holds:
  - active-low segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK;
  - NUM_DIGITS=6;
  - field limits HOURS_MAX=23, MINSEC_MAX=59.
- One natural sub-module: seg7_decode. It is combinational, maps 4-bit BCD plus blank/dash flags to 7-bit active-low segments, and is reusable by other display blocks.

Test Plan:
All scenarios use REFRESH_DIV=4.
1. Reset with inputs 12/34/56:
   - outputs idle until first lit;
   - first frame shows 0 on every digit (idx0 an=111110, seg=1000000);
   - after the first 5→0 wrap: idx0 seg=0000010 ('6'), idx1 '5'=0010010, idx2 '4'=0011001 with dp=0, idx3 '3'=0110000, idx4 '2'=0100100 with dp=0, idx5 '1'=1111001 with an=011111.
2. Change sec from 56 to 57 mid-frame:
   - display still shows 56 until the next wrap;
   - then idx0 shows '7'=1111000 and dp stays 1 on idx2/idx4.
3. Input 23/59/59, then 0/0/0 (boundary of the upstream counter wrap):
   - digits read 2,3,5,9,5,9;
   - after the next wrap all digits read '0';
   - with BLANK_HTENS=1, idx5 shows 1111111.
4. Input hours=24, min=60, sec=05:
   - idx2..idx5 show 0111111;
   - idx0 shows '5', idx1 shows '0';
   - dp=1 on all digits (sec odd).
5. en deasserted for 10 cycles mid-digit:
   - an=111111 from the next cycle;
   - on re-enable the same index resumes and completes its remaining count cycles;
   - a one-hot checker sees no cycle with two anodes low.
6. reset_n pulsed low for 3 ns between clock edges mid-scan:
   - outputs go to reset values asynchronously;
   - after release, scanning restarts at idx0 and the snapshot reads 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for seven-segment display blocks: active-low glyphs,
// digit count, time-field limits and a small fixed-range BCD helper.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned FIELD_W    = 6;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned BCD_W      = 4;

  localparam logic [FIELD_W-1:0] HOURS_MAX  = FIELD_W'(23);
  localparam logic [FIELD_W-1:0] MINSEC_MAX = FIELD_W'(59);

  // Segment order {g,f,e,d,c,b,a}, active-low.
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Tens digit of a 0..63 value by threshold compare; avoids a divider.
  function automatic logic [BCD_W-1:0] bcd_tens(input logic [FIELD_W-1:0] v);
    if (v >= FIELD_W'(60))      return BCD_W'(6);
    else if (v >= FIELD_W'(50)) return BCD_W'(5);
    else if (v >= FIELD_W'(40)) return BCD_W'(4);
    else if (v >= FIELD_W'(30)) return BCD_W'(3);
    else if (v >= FIELD_W'(20)) return BCD_W'(2);
    else if (v >= FIELD_W'(10)) return BCD_W'(1);
    else                        return BCD_W'(0);
  endfunction

  // Ones digit: subtract tens*10 built from shifts.
  function automatic logic [BCD_W-1:0] bcd_ones(input logic [FIELD_W-1:0] v);
    logic [FIELD_W-1:0] t10;
    t10 = FIELD_W'(bcd_tens(v));
    return BCD_W'(v - ((t10 << 3) + (t10 << 1)));
  endfunction

endpackage

// File: rtl/hms_seg7_scan_if.sv
// Time-field inputs and multiplexed display outputs of the seven-segment scanner.
interface hms_seg7_scan_if;
  import seg7_pkg::*;

  logic                  en;
  logic [FIELD_W-1:0]    hours;
  logic [FIELD_W-1:0]    min;
  logic [FIELD_W-1:0]    sec;
  logic [NUM_DIGITS-1:0] an;
  logic [SEG_W-1:0]      seg;
  logic                  dp;

  modport master (output en, hours, min, sec, input an, seg, dp);
  modport slave  (input en, hours, min, sec, output an, seg, dp);

endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder with dash/blank overrides.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  input  logic             blank,
  input  logic             dash,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (dash) begin
      seg_c = SEG_DASH;
    end else if (!blank) begin
      case (bcd)
        BCD_W'(0): seg_c = SEG_0;
        BCD_W'(1): seg_c = SEG_1;
        BCD_W'(2): seg_c = SEG_2;
        BCD_W'(3): seg_c = SEG_3;
        BCD_W'(4): seg_c = SEG_4;
        BCD_W'(5): seg_c = SEG_5;
        BCD_W'(6): seg_c = SEG_6;
        BCD_W'(7): seg_c = SEG_7;
        BCD_W'(8): seg_c = SEG_8;
        BCD_W'(9): seg_c = SEG_9;
        default:   seg_c = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/hms_seg7_scan.sv
// Six-digit HH.MM.SS multiplexed common-anode display driver with per-frame
// snapshot of the time fields, BCD split, range dashes and blinking separators.
module hms_seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          BLANK_HTENS = 1'b0
) (
  input logic            clk,
  input logic            reset_n,
  hms_seg7_scan_if.slave bus
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [FIELD_W-1:0]    snap_hours;
  logic [FIELD_W-1:0]    snap_min;
  logic [FIELD_W-1:0]    snap_sec;
  logic [NUM_DIGITS-1:0] an_q;
  logic [SEG_W-1:0]      seg_q;
  logic                  dp_q;

  logic [FIELD_W-1:0]    fval_c;
  logic                  fbad_c;
  logic [BCD_W-1:0]      tens_c;
  logic [BCD_W-1:0]      ones_c;
  logic [BCD_W-1:0]      digit_c;
  logic                  blank_c;
  logic                  dp_c;
  logic [NUM_DIGITS-1:0] an_c;
  logic [SEG_W-1:0]      seg_c;

  wire terminal = (cnt == CNT_LAST);

  // Refresh counter, digit index and frame snapshot; all frozen while disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      idx        <= '0;
      snap_hours <= '0;
      snap_min   <= '0;
      snap_sec   <= '0;
    end else if (bus.en) begin
      if (terminal) begin
        cnt <= '0;
        if (idx == IDX_LAST) begin
          idx        <= '0;
          snap_hours <= bus.hours;
          snap_min   <= bus.min;
          snap_sec   <= bus.sec;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Select the field shown by the current digit and derive its glyph controls.
  always_comb begin
    fval_c = snap_sec;
    fbad_c = 1'b0;
    case (idx)
      IDX_W'(0), IDX_W'(1): begin
        fval_c = snap_sec;
        fbad_c = (snap_sec > MINSEC_MAX);
      end
      IDX_W'(2), IDX_W'(3): begin
        fval_c = snap_min;
        fbad_c = (snap_min > MINSEC_MAX);
      end
      IDX_W'(4), IDX_W'(5): begin
        fval_c = snap_hours;
        fbad_c = (snap_hours > HOURS_MAX);
      end
      default: begin
        fval_c = snap_sec;
        fbad_c = 1'b1;
      end
    endcase
    tens_c  = bcd_tens(fval_c);
    ones_c  = bcd_ones(fval_c);
    digit_c = idx[0] ? tens_c : ones_c;
    blank_c = BLANK_HTENS && (idx == IDX_LAST) && !fbad_c && (tens_c == BCD_W'(0));
    dp_c    = ~(((idx == IDX_W'(2)) || (idx == IDX_W'(4))) &&
                (snap_sec <= MINSEC_MAX) && !snap_sec[0]);
    an_c    = ~(NUM_DIGITS'(1) << idx);
  end

  seg7_decode u_decode (
    .bcd   (digit_c),
    .blank (blank_c),
    .dash  (fbad_c),
    .seg_c (seg_c)
  );

  // Registered display drive; idle pattern whenever disabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_q  <= '1;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else if (bus.en) begin
      an_q  <= an_c;
      seg_q <= seg_c;
      dp_q  <= dp_c;
    end else begin
      an_q  <= '1;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_hms_seg7_scan.sv
// Randomized bench for hms_seg7_scan: two instances (hours-tens blanking off/on)
// compared every cycle against a frame/position arithmetic reference model.
module tb_hms_seg7_scan;

  localparam int unsigned RD    = 4;
  localparam int unsigned FRAME = 6 * RD;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  int checks = 0;
  int errors = 0;

  hms_seg7_scan_if bus0 ();
  hms_seg7_scan_if bus1 ();

  hms_seg7_scan #(.REFRESH_DIV(RD), .BLANK_HTENS(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );
  hms_seg7_scan #(.REFRESH_DIV(RD), .BLANK_HTENS(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Glyph a digit position should show for a given held time.
  function automatic logic [6:0] ref_seg(input int d, input int h, input int m,
                                         input int s, input bit blank_ht);
    int v, lim, dig;
    v   = (d < 2) ? s : (d < 4) ? m : h;
    lim = (d < 4) ? 59 : 23;
    if (v > lim) return 7'b0111111;
    dig = (d % 2 == 0) ? (v % 10) : (v / 10);
    if (blank_ht && d == 5 && dig == 0) return 7'b1111111;
    return seg_tab[dig];
  endfunction

  // Reference model: position = enabled cycles since reset.
  int         pos = 0;
  int         sh = 0, sm = 0, ss = 0;
  logic [5:0] exp_an   = 6'h3f;
  logic [6:0] exp_seg0 = 7'h7f;
  logic [6:0] exp_seg1 = 7'h7f;
  logic       exp_dp   = 1'b1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos = 0; sh = 0; sm = 0; ss = 0;
      exp_an = 6'h3f; exp_seg0 = 7'h7f; exp_seg1 = 7'h7f; exp_dp = 1'b1;
    end else if (bus0.en) begin
      int d;
      d        = (pos / RD) % 6;
      exp_an   = 6'h3f;
      exp_an[d] = 1'b0;
      exp_seg0 = ref_seg(d, sh, sm, ss, 1'b0);
      exp_seg1 = ref_seg(d, sh, sm, ss, 1'b1);
      exp_dp   = !((d == 2 || d == 4) && ss <= 59 && ss % 2 == 0);
      if (pos % FRAME == FRAME - 1) begin
        sh = int'(bus0.hours); sm = int'(bus0.min); ss = int'(bus0.sec);
      end
      pos++;
    end else begin
      exp_an = 6'h3f; exp_seg0 = 7'h7f; exp_seg1 = 7'h7f; exp_dp = 1'b1;
    end
  end

  always @(negedge clk) begin
    check_eq("an0",  16'(bus0.an),  16'(exp_an));
    check_eq("seg0", 16'(bus0.seg), 16'(exp_seg0));
    check_eq("dp0",  16'(bus0.dp),  16'(exp_dp));
    check_eq("an1",  16'(bus1.an),  16'(exp_an));
    check_eq("seg1", 16'(bus1.seg), 16'(exp_seg1));
    check_eq("dp1",  16'(bus1.dp),  16'(exp_dp));
    check_eq("onehot", 16'($countones(~bus0.an) <= 1 && $countones(~bus1.an) <= 1), 16'd1);
  end

  task automatic set_en(input logic e);
    bus0.en = e;
    bus1.en = e;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    bus0.hours = 6'(h); bus0.min = 6'(m); bus0.sec = 6'(s);
    bus1.hours = 6'(h); bus1.min = 6'(m); bus1.sec = 6'(s);
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    set_en(1'b0);
    set_time(12, 34, 56);
    run(3);
    reset_n = 1'b1;
    run(2);
    check_eq("idle_an", 16'(bus0.an), 16'h3f);
    set_en(1'b1);
    @(negedge clk);
    check_eq("first_an",  16'(bus0.an),  16'(6'b111110));
    check_eq("first_seg", 16'(bus0.seg), 16'(7'b1000000));
    run(2 * FRAME + 5);

    set_time(12, 34, 57);
    run(2 * FRAME);

    set_time(23, 59, 59);
    run(2 * FRAME);
    set_time(0, 0, 0);
    run(2 * FRAME);

    set_time(24, 60, 5);
    run(2 * FRAME + 1);

    set_en(1'b0);
    run(10);
    set_en(1'b1);
    run(FRAME + 3);

    // Asynchronous reset pulse between clock edges.
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check_eq("rst_an",  16'(bus0.an),  16'h3f);
    check_eq("rst_seg", 16'(bus1.seg), 16'h7f);
    check_eq("rst_dp",  16'(bus0.dp),  16'd1);
    #2 reset_n = 1'b1;
    set_time(7, 8, 9);
    run(2 * FRAME);

    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0)
        set_time(int'($urandom_range(0, 27)), int'($urandom_range(0, 63)),
                 int'($urandom_range(0, 63)));
      set_en($urandom_range(0, 19) != 0);
    end
    set_en(1'b1);
    run(FRAME);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
